// File: rtl/mem_dump_ctrl.sv
// Memory dump controller: reads a byte range and streams it to a UART transmitter.
// Optional trailing checksum byte when DUMP_CHECKSUM_EN is defined.
module mem_dump_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_addr,
    input  logic [ADDR_W-1:0] End_addr,
    output logic              Mem_en,
    output logic [ADDR_W-1:0] Mem_addr,
    input  logic [7:0]        Mem_rdata,
    output logic [7:0]        Tx_data,
    output logic              Tx_start,
    input  logic              Tx_done,
    output logic              Busy,
    output logic              Fin
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_MEM,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_end_addr;
    logic [1:0]        r_lat_cnt;
    logic [7:0]        r_tx_data;

    logic w_accept;
    logic w_capture;
    logic w_advance;
    logic w_last;

`ifdef DUMP_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_ck_sent;
    logic       w_ck_load;
`endif

    assign Mem_addr = r_cur_addr;
    assign Tx_data  = r_tx_data;

    always_comb begin
        w_next    = r_state;
        Mem_en    = 1'b0;
        Tx_start  = 1'b0;
        Fin       = 1'b0;
        Busy      = 1'b1;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        w_last    = (r_cur_addr == r_end_addr);
`ifdef DUMP_CHECKSUM_EN
        w_ck_load = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = READ;
                end
            end
            READ: begin
                Mem_en = 1'b1;
                w_next = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_capture = 1'b1;
                    w_next    = SEND;
                end
            end
            SEND: begin
                Tx_start = 1'b1;
                w_next   = WAIT_TX;
            end
            WAIT_TX: begin
                if (Tx_done) begin
`ifdef DUMP_CHECKSUM_EN
                    // After the last data byte the running sum goes out once more
                    if (r_ck_sent) begin
                        w_next = DONE;
                    end else if (w_last) begin
                        w_ck_load = 1'b1;
                        w_next    = SEND;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = READ;
                    end
`else
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = READ;
                    end
`endif
                end
            end
            DONE: begin
                Busy   = 1'b0;
                Fin    = 1'b1;
                w_next = IDLE;
            end
            default: begin
                Busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_cur_addr <= '0;
            r_end_addr <= '0;
            r_lat_cnt  <= '0;
            r_tx_data  <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_sum      <= '0;
            r_ck_sent  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cur_addr <= Start_addr;
                r_end_addr <= End_addr;
`ifdef DUMP_CHECKSUM_EN
                r_sum      <= '0;
                r_ck_sent  <= 1'b0;
`endif
            end
            if (w_advance) begin
                r_cur_addr <= r_cur_addr + ADDR_W'(1);
            end
            // Latency counter restarts on every read request
            if (r_state == READ) begin
                r_lat_cnt <= '0;
            end else if (r_state == WAIT_MEM) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end
            if (w_capture) begin
                r_tx_data <= Mem_rdata;
`ifdef DUMP_CHECKSUM_EN
                r_sum     <= r_sum + Mem_rdata;
`endif
            end
`ifdef DUMP_CHECKSUM_EN
            if (w_ck_load) begin
                r_tx_data <= r_sum;
                r_ck_sent <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: memory address width.
REQ-002 SHALL have parameter MEM_LAT, default 1: memory read latency in cycles, range 1..4.
REQ-003 SHALL have port Clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port Rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port Start, input, 1: level sampled each cycle; begins a dump when high in IDLE.
REQ-006 SHALL have port Start_addr, input, ADDR_W: first address, sampled with Start.
REQ-007 SHALL have port End_addr, input, ADDR_W: last address (inclusive), sampled with Start.
REQ-008 SHALL have port Mem_en, output, 1: memory read enable.
REQ-009 SHALL have port Mem_addr, output, ADDR_W: memory read address.
REQ-010 SHALL have port Mem_rdata, input, 8: memory read data, valid MEM_LAT cycles after Mem_en.
REQ-011 SHALL have port Tx_data, output, 8: byte to the UART transmitter.
REQ-012 SHALL have port Tx_start, output, 1: one-cycle request to the UART transmitter.
REQ-013 SHALL have port Tx_done, input, 1: one-cycle pulse from the UART transmitter when a byte finishes.
REQ-014 SHALL have port Busy, output, 1: high from the cycle after Start is accepted until Fin.
REQ-015 SHALL have port Fin, output, 1: one-cycle pulse at end of dump.

Function
REQ-016 SHALL implement states IDLE, READ, WAIT_MEM, SEND, WAIT_TX, DONE.
REQ-017 IDLE with Start=1 SHALL latch Start_addr into the current-address register and End_addr into the end register, clear the byte count, and go to READ.
REQ-018 READ SHALL assert Mem_en=1 for exactly one cycle with Mem_addr=current address, then go to WAIT_MEM.
REQ-019 WAIT_MEM SHALL wait MEM_LAT cycles after the READ cycle, then capture Mem_rdata into Tx_data and go to SEND.
REQ-020 SEND SHALL assert Tx_start=1 for exactly one cycle, then go to WAIT_TX.
REQ-021 WAIT_TX SHALL hold until Tx_done=1; Tx_done seen in any other state SHALL be ignored.
REQ-022 On Tx_done with current address equal to End_addr, SHALL go to DONE; otherwise SHALL increment current address modulo 2^ADDR_W and go to READ.
REQ-023 End_addr < Start_addr SHALL wrap through the maximum address to 0 (e.g. 0xFFFE..0x0001 sends 4 bytes); Start_addr == End_addr SHALL send exactly 1 byte.
REQ-024 DONE SHALL assert Fin=1 for one cycle, deassert Busy in that same cycle, and return to IDLE.
REQ-025 Start asserted while not in IDLE SHALL be ignored; Start held high through DONE SHALL begin a new dump from IDLE the following cycle.
REQ-026 Tx_data SHALL remain stable from SEND until the next capture.
REQ-027 Mem_addr SHALL always equal the current-address register.

Reset
REQ-028 Rst=1 SHALL force state IDLE, Mem_en=0, Tx_start=0, Busy=0, Fin=0, Tx_data=0, Mem_addr=0, and checksum=0 on the next edge, overriding every other input.
REQ-029 Rst mid-dump SHALL abort without a Fin pulse; a Tx_done arriving after reset SHALL be ignored.

Configuration
REQ-030 With DUMP_CHECKSUM_EN defined, SHALL keep an 8-bit modulo-256 sum of all captured bytes (cleared on Start accept) and, after the last data byte's Tx_done, SHALL send the sum as one extra byte through SEND/WAIT_TX before DONE.
REQ-031 Without DUMP_CHECKSUM_EN, no checksum logic SHALL exist and behaviour SHALL be exactly REQ-016..027.

Verification
REQ-032 Start_addr=0x0010, End_addr=0x0013, memory 0xA1..0xA4, Tx_done 10 cycles after each Tx_start -> 4 Tx_start pulses carrying A1,A2,A3,A4; one Fin pulse; Busy low afterwards.
REQ-033 Start_addr=End_addr=0x0005 -> exactly 1 byte sent, then Fin.
REQ-034 Start_addr=0xFFFE, End_addr=0x0001 -> Mem_addr sequence FFFE,FFFF,0000,0001; 4 bytes; Fin.
REQ-035 MEM_LAT=3 -> Tx_data captured 3 cycles after each Mem_en; a second Start pulse mid-dump is ignored.
REQ-036 Rst during WAIT_TX of byte 2 -> all outputs at reset values next cycle, no Fin, a late Tx_done causes no Tx_start.
REQ-037 DUMP_CHECKSUM_EN, bytes 0x80,0x90 -> third byte 0x10 sent, then Fin.
